// File: rtl/wb_boot_copier.sv
// Purpose: Wishbone master that copies len_i 32-bit words from src_i to dst_i, one read then one write per word.
// Latency: two cycles per word against a zero-wait slave; start to busy_o is one cycle, and the last ack to done_o is one cycle.
// Backpressure: holds cyc/stb on each access until wb_ack_i arrives; after TIMEOUT cycles without an ack it aborts with err_o set.
module wb_boot_copier #(
   parameter int TIMEOUT = 256
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [31:0] src_i,
   input  logic [31:0] dst_i,
   input  logic [15:0] len_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   output logic [31:0] wb_adr_o,
   output logic        wb_we_o,
   output logic        wb_tga_o,
   output logic        wb_stb_o,
   output logic        wb_cyc_o,
   output logic [1:0]  wb_sel_o,
   input  logic        wb_ack_i
);

   // The wait counter only needs to reach TIMEOUT-1; the abort happens on that cycle.
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [31:0]   src_q, src_d;
   logic [31:0]   dst_q, dst_d;
   logic [15:0]   rem_q, rem_d;
   logic [31:0]   dat_q, dat_d;
   logic [31:0]   adr_q, adr_d;
   logic [CW-1:0] tmo_q, tmo_d;
   logic          we_q, we_d;
   logic          cyc_q, cyc_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          err_q, err_d;

   logic          tmo_hit;

   // The wait limit is reached only while the bus is strobed; an ack on the same cycle still wins.
   assign tmo_hit = (tmo_q == TMO_LAST);

   // Next-state and next-output logic for the IDLE/READ/WRITE copy sequence.
   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      rem_d   = rem_q;
      dat_d   = dat_q;
      adr_d   = adr_q;
      tmo_d   = tmo_q;
      we_d    = we_q;
      cyc_d   = cyc_q;
      busy_d  = busy_q;
      done_d  = done_q;
      err_d   = err_q;

      case (state_q)
         S_IDLE: begin
            // A stray ack from the slave is meaningless here and is ignored.
            if (start_i) begin
               err_d = 1'b0;
               if (len_i == 16'd0) begin
                  // With nothing to copy, report completion without touching the bus.
                  done_d = 1'b1;
               end else begin
                  done_d  = 1'b0;
                  src_d   = src_i;
                  dst_d   = dst_i;
                  rem_d   = len_i;
                  adr_d   = src_i;
                  we_d    = 1'b0;
                  cyc_d   = 1'b1;
                  busy_d  = 1'b1;
                  tmo_d   = '0;
                  state_d = S_READ;
               end
            end
         end

         S_READ: begin
            if (wb_ack_i) begin
               // Capture the word. cyc stays high straight into the write.
               dat_d   = wb_dat_i;
               adr_d   = dst_q;
               we_d    = 1'b1;
               tmo_d   = '0;
               state_d = S_WRITE;
            end else if (tmo_hit) begin
               cyc_d   = 1'b0;
               we_d    = 1'b0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               tmo_d = tmo_q + CW'(1);
            end
         end

         S_WRITE: begin
            if (wb_ack_i) begin
               // Addresses wrap naturally at 2^32. The low bits pass through untouched.
               src_d = src_q + 32'd4;
               dst_d = dst_q + 32'd4;
               rem_d = rem_q - 16'd1;
               we_d  = 1'b0;
               tmo_d = '0;
               if (rem_q == 16'd1) begin
                  cyc_d   = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  err_d   = 1'b0;
                  state_d = S_IDLE;
               end else begin
                  adr_d   = src_q + 32'd4;
                  state_d = S_READ;
               end
            end else if (tmo_hit) begin
               cyc_d   = 1'b0;
               we_d    = 1'b0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               tmo_d = tmo_q + CW'(1);
            end
         end

         default: begin
            // An unreachable encoding recovers to a quiet idle bus.
            cyc_d   = 1'b0;
            we_d    = 1'b0;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and registered bus outputs. Reset clears everything at once, even mid-transfer.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         rem_q   <= '0;
         dat_q   <= '0;
         adr_q   <= '0;
         tmo_q   <= '0;
         we_q    <= 1'b0;
         cyc_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         rem_q   <= rem_d;
         dat_q   <= dat_d;
         adr_q   <= adr_d;
         tmo_q   <= tmo_d;
         we_q    <= we_d;
         cyc_q   <= cyc_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // stb always tracks cyc because this master never idles inside a bus cycle.
   assign wb_cyc_o = cyc_q;
   assign wb_stb_o = cyc_q;
   assign wb_we_o  = we_q;
   assign wb_adr_o = adr_q;
   assign wb_dat_o = dat_q;
   assign wb_tga_o = 1'b0;
   assign wb_sel_o = 2'b11;
   assign busy_o   = busy_q;
   assign done_o   = done_q;
   assign err_o    = err_q;

endmodule

// File: tb/tb_wb_boot_copier.sv
// Directed bench for wb_boot_copier with a small ROM/RAM slave whose ack latency is programmable.
// Bus accesses are logged on each rising edge. Checks run on falling edges against hand-computed values.
// The slave ack can be turned off completely to force the wait-limit abort.
module tb_wb_boot_copier;

   typedef struct packed {
      logic [31:0] adr;
      logic [31:0] dat;
   } xfer_t;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        start_i = 1'b0;
   logic [31:0] src_i = '0;
   logic [31:0] dst_i = '0;
   logic [15:0] len_i = '0;
   logic        busy_o, done_o, err_o;
   logic [31:0] wb_dat_i, wb_dat_o, wb_adr_o;
   logic        wb_we_o, wb_tga_o, wb_stb_o, wb_cyc_o, wb_ack_i;
   logic [1:0]  wb_sel_o;

   int          errs = 0;
   int          checks = 0;

   logic        ack_en = 1'b1;
   int          ack_lat = 0;
   int          lat_cnt = 0;
   int          busy_cnt = 0;
   int          stb_cnt = 0;
   int          cyc_cnt = 0;
   xfer_t       rd_q[$];
   xfer_t       wr_q[$];
   int          b0, s0, c0;

   wb_boot_copier #(.TIMEOUT(8)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
      .src_i(src_i), .dst_i(dst_i), .len_i(len_i),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
      .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_adr_o(wb_adr_o),
      .wb_we_o(wb_we_o), .wb_tga_o(wb_tga_o), .wb_stb_o(wb_stb_o),
      .wb_cyc_o(wb_cyc_o), .wb_sel_o(wb_sel_o), .wb_ack_i(wb_ack_i)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
   endfunction

   // Combinational slave. Read data comes from the address pattern; ack comes after ack_lat wait cycles.
   assign wb_dat_i = rom_word(wb_adr_o);
   assign wb_ack_i = wb_cyc_o && wb_stb_o && ack_en && (lat_cnt >= ack_lat);

   // Wait-cycle counter and access log. Each block sees the values from the cycle that just ended.
   always @(posedge clk_i) begin
      if (wb_cyc_o && wb_stb_o && !wb_ack_i) lat_cnt <= lat_cnt + 1;
      else                                   lat_cnt <= 0;
      if (busy_o)   busy_cnt <= busy_cnt + 1;
      if (wb_stb_o) stb_cnt  <= stb_cnt + 1;
      if (wb_cyc_o) cyc_cnt  <= cyc_cnt + 1;
      if (wb_cyc_o && wb_stb_o && wb_ack_i && !rst_i) begin
         if (wb_we_o) wr_q.push_back({wb_adr_o, wb_dat_o});
         else         rd_q.push_back({wb_adr_o, wb_dat_i});
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
      @(negedge clk_i);
      src_i = s; dst_i = d; len_i = n; start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 300; i++) begin
         if (!busy_o) break;
         @(negedge clk_i);
      end
      chk("idle_reached", {31'd0, busy_o}, 32'd0);
   endtask

   task automatic snap();
      b0 = busy_cnt; s0 = stb_cnt; c0 = cyc_cnt;
      rd_q.delete(); wr_q.delete();
   endtask

   task automatic chk_copy(input string tag, input logic [31:0] s, input logic [31:0] d, input int n);
      chk({tag, "_nrd"}, rd_q.size(), n);
      chk({tag, "_nwr"}, wr_q.size(), n);
      for (int i = 0; i < n; i++) begin
         if (i < rd_q.size()) chk({tag, "_rdadr"}, rd_q[i].adr, s + 32'(4 * i));
         if (i < wr_q.size()) begin
            chk({tag, "_wradr"}, wr_q[i].adr, d + 32'(4 * i));
            chk({tag, "_wrdat"}, wr_q[i].dat, rom_word(s + 32'(4 * i)));
         end
      end
   endtask

   initial begin
      // Reset state
      #1;
      chk("rst_cyc",  {31'd0, wb_cyc_o}, 32'd0);
      chk("rst_stb",  {31'd0, wb_stb_o}, 32'd0);
      chk("rst_busy", {31'd0, busy_o},   32'd0);
      chk("rst_done", {31'd0, done_o},   32'd0);
      chk("rst_err",  {31'd0, err_o},    32'd0);
      chk("rst_adr",  wb_adr_o,          32'd0);
      chk("rst_sel",  {30'd0, wb_sel_o}, 32'd3);
      chk("rst_tga",  {31'd0, wb_tga_o}, 32'd0);
      @(negedge clk_i); @(negedge clk_i);
      rst_i = 1'b0;

      // len=0: done without any bus cycle
      snap();
      pulse_start(32'h0000_0500, 32'h0000_0600, 16'd0);
      chk("len0_done", {31'd0, done_o}, 32'd1);
      chk("len0_err",  {31'd0, err_o},  32'd0);
      chk("len0_busy", {31'd0, busy_o}, 32'd0);
      @(negedge clk_i);
      chk("len0_nocyc", cyc_cnt - c0, 32'd0);

      // Zero-wait copy of four words
      ack_lat = 0; ack_en = 1'b1;
      snap();
      pulse_start(32'h0000_0100, 32'h0002_0000, 16'd4);
      chk("z4_busy_hi", {31'd0, busy_o}, 32'd1);
      chk("z4_done_lo", {31'd0, done_o}, 32'd0);
      chk("z4_rd0_adr", wb_adr_o, 32'h0000_0100);
      wait_idle();
      chk_copy("z4", 32'h0000_0100, 32'h0002_0000, 4);
      chk("z4_busycyc", busy_cnt - b0, 32'd8);
      chk("z4_done", {31'd0, done_o}, 32'd1);
      chk("z4_err",  {31'd0, err_o},  32'd0);
      chk("z4_cyc_lo", {31'd0, wb_cyc_o}, 32'd0);
      chk("z4_dat_hold", wb_dat_o, rom_word(32'h0000_010C));

      // Slave with three wait cycles, two words
      ack_lat = 3;
      snap();
      pulse_start(32'h0000_0400, 32'h0000_0800, 16'd2);
      @(negedge clk_i); @(negedge clk_i);
      chk("l3_stb_held", {31'd0, wb_stb_o}, 32'd1);
      chk("l3_adr_held", wb_adr_o, 32'h0000_0400);
      chk("l3_we_lo",    {31'd0, wb_we_o}, 32'd0);
      wait_idle();
      chk_copy("l3", 32'h0000_0400, 32'h0000_0800, 2);
      chk("l3_busycyc", busy_cnt - b0, 32'd16);
      chk("l3_err", {31'd0, err_o}, 32'd0);

      // Slave that never acks: abort after 8 strobed cycles
      ack_en = 1'b0; ack_lat = 0;
      snap();
      pulse_start(32'h0000_1000, 32'h0000_2000, 16'd3);
      wait_idle();
      chk("to_stbcyc", stb_cnt - s0, 32'd8);
      chk("to_done", {31'd0, done_o}, 32'd1);
      chk("to_err",  {31'd0, err_o},  32'd1);
      chk("to_nwr",  wr_q.size(), 32'd0);
      chk("to_cyc_lo", {31'd0, wb_cyc_o}, 32'd0);
      ack_en = 1'b1;

      // Source address wraps past 2^32
      snap();
      pulse_start(32'hFFFF_FFFC, 32'h0000_3000, 16'd2);
      chk("wr_err_clr", {31'd0, err_o}, 32'd0);
      wait_idle();
      chk_copy("wrap", 32'hFFFF_FFFC, 32'h0000_3000, 2);
      if (rd_q.size() > 1) chk("wrap_rd1", rd_q[1].adr, 32'h0000_0000);

      // Reset during the write of word 2, then restart right after release
      snap();
      pulse_start(32'h0000_0200, 32'h0000_5000, 16'd4);
      @(negedge clk_i); @(negedge clk_i); @(negedge clk_i);
      chk("mid_we",  {31'd0, wb_we_o}, 32'd1);
      chk("mid_adr", wb_adr_o, 32'h0000_5004);
      rst_i = 1'b1;
      #1;
      chk("mid_cyc",  {31'd0, wb_cyc_o}, 32'd0);
      chk("mid_stb",  {31'd0, wb_stb_o}, 32'd0);
      chk("mid_busy", {31'd0, busy_o},   32'd0);
      chk("mid_done", {31'd0, done_o},   32'd0);
      chk("mid_dat",  wb_dat_o,          32'd0);
      chk("mid_nwr",  wr_q.size(),       32'd1);
      @(negedge clk_i);
      snap();
      rst_i = 1'b0;
      src_i = 32'h0000_0200; dst_i = 32'h0000_6000; len_i = 16'd4; start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      chk("post_busy", {31'd0, busy_o}, 32'd1);
      wait_idle();
      chk_copy("post", 32'h0000_0200, 32'h0000_6000, 4);
      chk("post_busycyc", busy_cnt - b0, 32'd8);
      chk("post_done", {31'd0, done_o}, 32'd1);
      chk("post_err",  {31'd0, err_o},  32'd0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/wb_boot_copier.md
WB_BOOT_COPIER -- requirements
Module: wb_boot_copier

Interface
REQ-001 SHALL have parameter TIMEOUT, default 256, meaning max cycles waited for wb_ack_i per access before abort.
REQ-002 SHALL have port clk_i  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start_i  input  1  begin copy; sampled only in IDLE.
REQ-005 SHALL have port src_i  input  32  byte address of first source word.
REQ-006 SHALL have port dst_i  input  32  byte address of first destination word.
REQ-007 SHALL have port len_i  input  16  number of 32-bit words to copy.
REQ-008 SHALL have port busy_o  output  1  copy in progress.
REQ-009 SHALL have port done_o  output  1  last copy finished (success or abort).
REQ-010 SHALL have port err_o  output  1  last copy aborted by timeout.
REQ-011 SHALL have port wb_dat_i  input  32  Wishbone read data.
REQ-012 SHALL have port wb_dat_o  output  32  Wishbone write data.
REQ-013 SHALL have port wb_adr_o  output  32  Wishbone byte address.
REQ-014 SHALL have port wb_we_o  output  1  write enable.
REQ-015 SHALL have port wb_tga_o  output  1  address tag, constant 0.
REQ-016 SHALL have port wb_stb_o  output  1  strobe.
REQ-017 SHALL have port wb_cyc_o  output  1  cycle.
REQ-018 SHALL have port wb_sel_o  output  2  byte-lane select, constant 2'b11 (full word).
REQ-019 SHALL have port wb_ack_i  input  1  slave acknowledge; may be combinational (same cycle as stb).

Function
REQ-020 SHALL implement FSM states IDLE, READ, WRITE; all Wishbone outputs registered.
REQ-021 IDLE: start_i=1 SHALL latch src_i, dst_i, len_i, clear done_o/err_o, assert busy_o next cycle; len_i=0 -> stay IDLE, set done_o=1, err_o=0, no bus cycle.
REQ-022 IDLE with start_i=1, len_i>0 SHALL go to READ; start_i while busy SHALL be ignored.
REQ-023 READ: cyc=stb=1, we=0, adr=current src; on edge with wb_ack_i=1 SHALL capture wb_dat_i into data register and go to WRITE.
REQ-024 WRITE: cyc=stb=1, we=1, adr=current dst, dat_o=captured data; on ack SHALL add 4 to src and dst, decrement remaining count.
REQ-025 WRITE ack with remaining==1 SHALL go to IDLE, deassert cyc/stb/busy, set done_o=1, err_o=0; otherwise go to READ.
REQ-026 With a zero-wait slave, each word SHALL take exactly 2 cycles; len N copy busy for 2N cycles.
REQ-027 cyc/stb SHALL deassert for one cycle between accesses is NOT required; cyc may stay high READ->WRITE->READ.
REQ-028 Address increment SHALL wrap modulo 2^32; no alignment check, low two bits carried unchanged.
REQ-029 Timeout counter SHALL clear on entering each access and count cycles with stb=1, ack=0; reaching TIMEOUT-1 without ack SHALL drop cyc/stb, go IDLE, set done_o=1, err_o=1.
REQ-030 Ack on the same cycle the counter reaches TIMEOUT-1 SHALL count as success (ack wins).
REQ-031 wb_ack_i while in IDLE SHALL be ignored.
REQ-032 done_o/err_o SHALL hold until next accepted start_i.
REQ-033 wb_dat_o SHALL hold its value outside WRITE (no requirement on contents).

Reset
REQ-034 rst_i=1 SHALL immediately force IDLE, cyc/stb/we/busy/done/err=0, adr/dat_o/data/counters=0, including mid-transfer.
REQ-035 After rst_i deasserts, block SHALL accept start_i on the first rising edge.

Verification
REQ-036 src=0x0000_0100, dst=0x0002_0000, len=4, zero-wait ROM/RAM model -> 4 reads 0x100..0x10C, 4 writes 0x20000..0x2000C, data matches, busy 8 cycles, done=1, err=0.
REQ-037 len=0 start -> no cyc asserted, done=1 next cycle, err=0.
REQ-038 slave with 3-cycle ack latency, len=2 -> each access holds stb until ack, busy 16 cycles, correct data.
REQ-039 TIMEOUT=8, slave never acks on first read -> stb drops after 8 cycles, done=1, err=1, no write issued.
REQ-040 src=0xFFFF_FFFC, len=2 -> second read address 0x0000_0000.
REQ-041 rst_i asserted during WRITE of word 2 of 4 -> cyc/stb low same cycle, busy=0, done=0; new start then completes normally.
